instruction_fetch_unit: RTL and testbench

- Initiator side of the instruction-memory interface.
- Owns the program counter and drives the 16-bit address into the combinational instruction ROM.
- Captures the returned 28-bit instruction word into a pipeline register and splits it into decoded fields for the execution stage.
- Supports a consumer stall, branch redirect with a one-cycle bubble, and pause/resume via enable.

---
 rtl/instruction_fetch_unit.sv | 116 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner and instruction capture stage; branch redirect enabled by FETCH_BRANCH_EN
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_ADDR = 16'd0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        iEnable,
    input  logic        iStall,
    input  logic        iBranchTaken,
    input  logic [15:0] iBranchTarget,
    input  logic [27:0] iInstruction,
    output logic [15:0] oAddress,
    output logic        oValid,
    output logic [27:0] oInstruction,
    output logic [15:0] oPC,
    output logic [3:0]  oOpcode,
    output logic [7:0]  oDestination,
    output logic [7:0]  oSource1,
    output logic [7:0]  oSource0,
    output logic [15:0] oLiteral
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic        valid_q;
    logic [27:0] instr_q;
    logic [15:0] instr_pc_q;
    logic        branch_taken;

`ifdef FETCH_BRANCH_EN
    assign branch_taken = iBranchTaken;
`else
    // Redirect inputs stay on the port list but have no effect in this build.
    logic unused_branch;
    assign unused_branch = ^{iBranchTaken, iBranchTarget};
    assign branch_taken  = 1'b0;
`endif

    // Fetch FSM: PC sequencing, capture into the output register, stall hold and redirect.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_ADDR;
            valid_q    <= 1'b0;
            instr_q    <= 28'd0;
            instr_pc_q <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (iEnable) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (!iEnable) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end else if (branch_taken) begin
`ifdef FETCH_BRANCH_EN
                        pc_q    <= iBranchTarget;
`endif
                        valid_q <= 1'b0;
                        state_q <= BUBBLE;
                    end else if (iStall && valid_q) begin
                        // Consumer not ready: everything holds.
                        state_q <= RUN;
                    end else begin
                        instr_q    <= iInstruction;
                        instr_pc_q <= pc_q;
                        pc_q       <= pc_q + 16'd1;
                        valid_q    <= 1'b1;
                    end
                end
                BUBBLE: begin
                    if (!iEnable) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end else if (branch_taken) begin
`ifdef FETCH_BRANCH_EN
                        pc_q    <= iBranchTarget;
`endif
                        state_q <= BUBBLE;
                    end else begin
                        // Output register is empty here, so stall cannot block this capture.
                        instr_q    <= iInstruction;
                        instr_pc_q <= pc_q;
                        pc_q       <= pc_q + 16'd1;
                        valid_q    <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign oAddress     = pc_q;
    assign oValid       = valid_q;
    assign oInstruction = instr_q;
    assign oPC          = instr_pc_q;
    assign oOpcode      = instr_q[27:24];
    assign oDestination = instr_q[23:16];
    assign oSource1     = instr_q[15:8];
    assign oSource0     = instr_q[7:0];
    assign oLiteral     = instr_q[15:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic        Clock;
    logic        Reset;
    logic        iEnable;
    logic        iStall;
    logic        iBranchTaken;
    logic [15:0] iBranchTarget;

    logic [27:0] rom_a, rom_w;
    logic [15:0] addr_a, addr_w;
    logic        valid_a, valid_w;
    logic [27:0] instr_a, instr_w;
    logic [15:0] pc_a, pc_w;
    logic [3:0]  opc_a, opc_w;
    logic [7:0]  dst_a, dst_w, s1_a, s1_w, s0_a, s0_w;
    logic [15:0] lit_a, lit_w;

    int tests_run;
    int tests_failed;

    assign rom_a = {4'h5, addr_a[7:0], addr_a};
    assign rom_w = {4'h5, addr_w[7:0], addr_w};

    instruction_fetch_unit dut (
        .Clock(Clock), .Reset(Reset), .iEnable(iEnable), .iStall(iStall),
        .iBranchTaken(iBranchTaken), .iBranchTarget(iBranchTarget),
        .iInstruction(rom_a), .oAddress(addr_a), .oValid(valid_a),
        .oInstruction(instr_a), .oPC(pc_a), .oOpcode(opc_a),
        .oDestination(dst_a), .oSource1(s1_a), .oSource0(s0_a), .oLiteral(lit_a)
    );

    instruction_fetch_unit #(.RESET_ADDR(16'hFFFE)) dut_w (
        .Clock(Clock), .Reset(Reset), .iEnable(iEnable), .iStall(iStall),
        .iBranchTaken(iBranchTaken), .iBranchTarget(iBranchTarget),
        .iInstruction(rom_w), .oAddress(addr_w), .oValid(valid_w),
        .oInstruction(instr_w), .oPC(pc_w), .oOpcode(opc_w),
        .oDestination(dst_w), .oSource1(s1_w), .oSource0(s0_w), .oLiteral(lit_w)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    // Advance n rising edges, leaving time 1 unit after the last edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #1;
        end
    endtask

    // Reset both instances, then release with iEnable=1; on return we are in cycle 0.
    task automatic start_run();
        Reset = 1'b1;
        iEnable = 1'b0;
        iStall = 1'b0;
        iBranchTaken = 1'b0;
        iBranchTarget = 16'h0000;
        tick(2);
        Reset = 1'b0;
        iEnable = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        iEnable = 1'b0;
        iStall = 1'b0;
        iBranchTaken = 1'b0;
        iBranchTarget = 16'h0000;
        tick(2);
        tests_run++;
        if (valid_a !== 1'b0 || addr_a !== 16'h0000 || instr_a !== 28'd0 || pc_a !== 16'h0000 ||
            opc_a !== 4'h0 || dst_a !== 8'h00 || s1_a !== 8'h00 || s0_a !== 8'h00 || lit_a !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_state: valid=%0h addr=%h instr=%h pc=%h opc=%h lit=%h expected all zero",
                     valid_a, addr_a, instr_a, pc_a, opc_a, lit_a);
        end
        tests_run++;
        if (addr_w !== 16'hFFFE || valid_w !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_addr_param: addr=%h valid=%0h expected fffe 0", addr_w, valid_w);
        end
        // Idle with enable low: nothing moves.
        Reset = 1'b0;
        tick(2);
        tests_run++;
        if (valid_a !== 1'b0 || addr_a !== 16'h0000) begin
            tests_failed++;
            $display("FAIL idle_hold: valid=%0h addr=%h expected 0 0000", valid_a, addr_a);
        end
        // Enable from cycle 0; stall in cycle 1 must not block the first capture.
        iEnable = 1'b1;
        tests_run++;
        if (valid_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL cycle0_valid: got %0h expected 0", valid_a);
        end
        tick(1);
        iStall = 1'b1;
        tests_run++;
        if (valid_a !== 1'b0 || addr_a !== 16'h0000) begin
            tests_failed++;
            $display("FAIL cycle1: valid=%0h addr=%h expected 0 0000", valid_a, addr_a);
        end
        tick(1);
        iStall = 1'b0;
        tests_run++;
        if (valid_a !== 1'b1 || pc_a !== 16'h0000 || instr_a !== 28'h5000000) begin
            tests_failed++;
            $display("FAIL cycle2_first: valid=%0h pc=%h instr=%h expected 1 0000 5000000", valid_a, pc_a, instr_a);
        end
        tick(1);
        tests_run++;
        if (pc_a !== 16'h0001 || opc_a !== 4'h5 || lit_a !== 16'h0001 || dst_a !== 8'h01 || s1_a !== 8'h00 || s0_a !== 8'h01) begin
            tests_failed++;
            $display("FAIL cycle3_fields: pc=%h opc=%h lit=%h dst=%h s1=%h s0=%h expected 0001 5 0001 01 00 01",
                     pc_a, opc_a, lit_a, dst_a, s1_a, s0_a);
        end
    endtask

    task automatic test_stall();
        start_run();
        tick(6);                      // cycle 6: oPC = 4
        tests_run++;
        if (pc_a !== 16'h0004 || addr_a !== 16'h0005) begin
            tests_failed++;
            $display("FAIL stall_pre: pc=%h addr=%h expected 0004 0005", pc_a, addr_a);
        end
        iStall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                tick(1);
                iStall = 1'b0;
            end else begin
                tick(1);
            end
            tests_run++;
            if (pc_a !== 16'h0004 || addr_a !== 16'h0005 || valid_a !== 1'b1) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: pc=%h addr=%h valid=%0h expected 0004 0005 1", k, pc_a, addr_a, valid_a);
            end
        end
        tick(1);
        tests_run++;
        if (pc_a !== 16'h0005 || valid_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_release: pc=%h valid=%0h expected 0005 1", pc_a, valid_a);
        end
    endtask

    task automatic test_branch();
        start_run();
        tick(5);                      // cycle 5: oPC = 3
        iBranchTaken = 1'b1;
        iBranchTarget = 16'h0100;
        tick(1);
        iBranchTaken = 1'b0;
`ifdef FETCH_BRANCH_EN
        tests_run++;
        if (valid_a !== 1'b0 || addr_a !== 16'h0100) begin
            tests_failed++;
            $display("FAIL branch_bubble: valid=%0h addr=%h expected 0 0100", valid_a, addr_a);
        end
        tick(1);
        tests_run++;
        if (valid_a !== 1'b1 || pc_a !== 16'h0100 || dst_a !== 8'h00) begin
            tests_failed++;
            $display("FAIL branch_target: valid=%0h pc=%h dst=%h expected 1 0100 00", valid_a, pc_a, dst_a);
        end
`else
        tests_run++;
        if (valid_a !== 1'b1 || pc_a !== 16'h0004) begin
            tests_failed++;
            $display("FAIL nobranch_seq0: valid=%0h pc=%h expected 1 0004", valid_a, pc_a);
        end
        tick(1);
        tests_run++;
        if (valid_a !== 1'b1 || pc_a !== 16'h0005) begin
            tests_failed++;
            $display("FAIL nobranch_seq1: valid=%0h pc=%h expected 1 0005", valid_a, pc_a);
        end
`endif
        // Disable and branch together: disable wins, PC held.
        iEnable = 1'b0;
        iBranchTaken = 1'b1;
        iBranchTarget = 16'h0200;
        tick(1);
        iBranchTaken = 1'b0;
        tests_run++;
`ifdef FETCH_BRANCH_EN
        if (valid_a !== 1'b0 || addr_a !== 16'h0101) begin
            tests_failed++;
            $display("FAIL branch_vs_disable: valid=%0h addr=%h expected 0 0101", valid_a, addr_a);
        end
`else
        if (valid_a !== 1'b0 || addr_a !== 16'h0006) begin
            tests_failed++;
            $display("FAIL branch_vs_disable: valid=%0h addr=%h expected 0 0006", valid_a, addr_a);
        end
`endif
    endtask

    task automatic test_wrap();
        start_run();
        tick(2);
        tests_run++;
        if (pc_w !== 16'hFFFE || valid_w !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap0: pc=%h valid=%0h expected fffe 1", pc_w, valid_w);
        end
        tick(1);
        tests_run++;
        if (pc_w !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL wrap1: pc=%h expected ffff", pc_w);
        end
        tick(1);
        tests_run++;
        if (pc_w !== 16'h0000 || lit_w !== 16'h0000) begin
            tests_failed++;
            $display("FAIL wrap2: pc=%h lit=%h expected 0000 0000", pc_w, lit_w);
        end
        tick(1);
        tests_run++;
        if (pc_w !== 16'h0001 || addr_w !== 16'h0002) begin
            tests_failed++;
            $display("FAIL wrap3: pc=%h addr=%h expected 0001 0002", pc_w, addr_w);
        end
    endtask

    task automatic test_pause();
        start_run();
        tick(9);                      // cycle 9: oPC = 7
        tests_run++;
        if (pc_a !== 16'h0007) begin
            tests_failed++;
            $display("FAIL pause_pre: pc=%h expected 0007", pc_a);
        end
        iEnable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            tests_run++;
            if (valid_a !== 1'b0 || addr_a !== 16'h0008) begin
                tests_failed++;
                $display("FAIL pause_hold[%0d]: valid=%0h addr=%h expected 0 0008", k, valid_a, addr_a);
            end
        end
        iEnable = 1'b1;
        tick(1);
        tests_run++;
        if (valid_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL resume_gap: valid=%0h expected 0", valid_a);
        end
        tick(1);
        tests_run++;
        if (valid_a !== 1'b1 || pc_a !== 16'h0008) begin
            tests_failed++;
            $display("FAIL resume: valid=%0h pc=%h expected 1 0008", valid_a, pc_a);
        end
    endtask

    task automatic test_async_reset();
        start_run();
        tick(5);
        tests_run++;
        if (valid_a !== 1'b1 || addr_a !== 16'h0004) begin
            tests_failed++;
            $display("FAIL async_pre: valid=%0h addr=%h expected 1 0004", valid_a, addr_a);
        end
        #2;
        Reset = 1'b1;
        #1;
        tests_run++;
        if (valid_a !== 1'b0 || addr_a !== 16'h0000 || pc_a !== 16'h0000 || instr_a !== 28'd0) begin
            tests_failed++;
            $display("FAIL async_reset: valid=%0h addr=%h pc=%h instr=%h expected 0 0000 0000 0", valid_a, addr_a, pc_a, instr_a);
        end
        tests_run++;
        if (valid_w !== 1'b0 || addr_w !== 16'hFFFE) begin
            tests_failed++;
            $display("FAIL async_reset_param: valid=%0h addr=%h expected 0 fffe", valid_w, addr_w);
        end
        tick(1);
        Reset = 1'b0;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        Reset = 1'b1;
        iEnable = 1'b0;
        iStall = 1'b0;
        iBranchTaken = 1'b0;
        iBranchTarget = 16'h0000;
        #1;
        test_reset();
        test_stall();
        test_branch();
        test_wrap();
        test_pause();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
